pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Parametrised program-counter and fetch-request controller for the pipelined RISC-V core's IF stage.
- Holds the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Advances sequentially, and applies branch/jump redirects and trap vectors with fixed priority.
- Adds stall support, a post-reset boot delay and a saturating redirect counter beyond a plain PC register.

## Interface
- ADDR_WIDTH, 32, PC/address width in bits
- RESET_VECTOR, 0, PC value loaded on reset
- INSTR_BYTES, 4, sequential increment (power of two, ≥ 2)
- BOOT_DELAY, 2, clock edges after reset release before first fetch request (0..255)
- CNT_WIDTH, 16, redirect counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard stall; blocks sequential advance only
- redirect_valid_i  in  1  branch/jump taken from EX
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- trap_valid_i  in  1  exception/interrupt entry
- trap_vec_i  in  ADDR_WIDTH  trap target
- fetch_ready_i  in  1  instruction memory accepts request
- fetch_valid_o  out  1  fetch request valid
- pc_o  out  ADDR_WIDTH  current fetch PC, registered
- pc_plus_o  out  ADDR_WIDTH  pc_o + INSTR_BYTES, combinational
- flush_o  out  1  one-cycle pulse, cycle after redirect/trap applied
- redirect_cnt_o  out  CNT_WIDTH  saturating count of applied redirects + traps
- misalign_o  out  1  misaligned-target pulse (see Configuration)

## Operation
- States: BOOT, RUN. Reset enters BOOT, with the boot counter = BOOT_DELAY; if BOOT_DELAY = 0, reset enters RUN directly.
- BOOT:
  - Counter decrements each edge.
  - At the edge where the counter is 1, state becomes RUN.
  - fetch_valid_o = 0 throughout.
- RUN: fetch_valid_o = 1 (registered from state); RUN is never left except via reset.
- PC update priority per edge:
  1. trap_valid_i → pc ← trap_vec_i.
  2. Else redirect_valid_i → pc ← redirect_pc_i.
  3. Else fire (fetch_valid_o & fetch_ready_i & !stall_i) → pc ← pc + INSTR_BYTES.
  4. Else hold.
- Trap/redirect override stall_i and fetch_ready_i. They are also applied in BOOT (pc updates; state stays BOOT, counter unaffected).
- Sequential add wraps modulo 2^ADDR_WIDTH (all-ones minus INSTR_BYTES-1 → 0); pc_plus_o wraps identically.
- Handshake: while fetch_valid_o = 1 and not fired, pc_o is stable unless a trap/redirect occurs. A redirect abandons the outstanding request; memory must key on pc_o at the fire edge.
- Simultaneous trap + redirect: trap wins, counter +1 (not +2), single flush_o pulse.
- redirect_cnt_o increments by 1 per edge with trap or redirect and saturates at all-ones.
- Reset mid-operation: immediate asynchronous return to reset values; any in-flight handshake is dropped.

## Timing
- Reset values:
  - pc_o = RESET_VECTOR.
  - fetch_valid_o = 0 (1 if BOOT_DELAY = 0).
  - flush_o = 0, redirect_cnt_o = 0, misalign_o = 0.
- Redirect/trap sampled at edge N: pc_o = target and flush_o = 1 during cycle N+1; flush_o = 0 at N+2 unless a new redirect occurs.
- Fire at edge N: pc_o = old pc + INSTR_BYTES in cycle N+1. One fetch per cycle max; back-to-back fires allowed.
- First fetch_valid_o = 1 in the cycle following the BOOT_DELAY-th rising edge after rst_n deassertion.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Condition: a trap/redirect target has any bit below log2(INSTR_BYTES) set.
  - misalign_o pulses for one cycle, aligned with flush_o.
  - The loaded pc has those low bits cleared.
- Undefined: targets are loaded unmodified; misalign_o is tied 0.

## Test plan
- Reset release, RESET_VECTOR = 0x1000, BOOT_DELAY = 2, fetch_ready_i = 1 → fetch_valid_o low for 2 edges; pc_o = 0x1000, 0x1004, 0x1008 on successive cycles once valid.
- fetch_ready_i = 0 for 3 cycles then 1, with stall_i = 1 during one ready cycle → pc_o holds 0x1004 until the first non-stalled ready edge, then 0x1008.
- redirect_valid_i = 1, redirect_pc_i = 0x2000, with stall_i = 1 and fetch_ready_i = 0 → pc_o = 0x2000 and flush_o = 1 next cycle; redirect_cnt_o = 1.
- Trap (0x80) and redirect (0x3000) on the same edge → pc_o = 0x80, redirect_cnt_o +1, one flush_o pulse; CNT_WIDTH = 2 with 5 redirects → redirect_cnt_o = 3.
- pc = 0xFFFF_FFFC, fire → pc_o = 0x0000_0000, pc_plus_o = 0x4.
- With PC_ALIGN_CHECK_EN, redirect to 0x2002 → pc_o = 0x2000, misalign_o = 1 for one cycle. Without the macro → pc_o = 0x2002, misalign_o = 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter and fetch-request controller for the IF stage.
//   Holds the fetch PC and issues requests to instruction memory over a
//   valid/ready handshake. Traps take priority over branch/jump redirects,
//   and redirects take priority over sequential advance. After reset the
//   block waits BOOT_DELAY edges before raising its first request.
//
// Parameters
//   ADDR_WIDTH    PC/address width in bits
//   RESET_VECTOR  PC value loaded on reset
//   INSTR_BYTES   sequential increment (power of two, >= 2)
//   BOOT_DELAY    edges after reset release before the first request (0..255)
//   CNT_WIDTH     width of the saturating redirect counter
//
// Ports
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   stall_i           hazard stall, blocks sequential advance only
//   redirect_valid_i  branch/jump taken, target on redirect_pc_i
//   trap_valid_i      exception/interrupt entry, target on trap_vec_i
//   fetch_ready_i     instruction memory accepts the request
//   fetch_valid_o     fetch request valid (high in RUN)
//   pc_o              current fetch PC (registered)
//   pc_plus_o         pc_o + INSTR_BYTES (combinational, wraps)
//   flush_o           one-cycle pulse in the cycle after a redirect/trap
//   redirect_cnt_o    saturating count of applied redirects and traps
//   misalign_o        misaligned-target pulse, aligned with flush_o
//
// Build option
//   PC_ALIGN_CHECK_EN  when defined, redirect/trap targets have their low
//                      log2(INSTR_BYTES) bits cleared and misalign_o pulses
//                      if any of those bits were set. When undefined,
//                      targets load unmodified and misalign_o is tied 0.

module pc_fetch_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INSTR_BYTES  = 4,
  parameter int BOOT_DELAY   = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_valid_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus_o,
  output logic                  flush_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt_o,
  output logic                  misalign_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC    = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [7:0]            BOOT_INIT = 8'(BOOT_DELAY);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // With no boot delay the block comes out of reset already requesting.
  localparam state_t RESET_STATE = (BOOT_DELAY == 0) ? RUN : BOOT;

  state_t                  state_reg, state_next;
  logic [7:0]              boot_cnt_reg, boot_cnt_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic                    flush_reg, flush_next;
  logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                    misalign_reg, misalign_next;

  logic                    jump_valid;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic [ADDR_WIDTH-1:0]   jump_load;
  logic                    target_misaligned;
  logic                    fire;

  // Trap beats redirect; both collapse into a single jump event so the
  // counter and flush only see one event per edge.
  assign jump_valid  = trap_valid_i | redirect_valid_i;
  assign jump_target = trap_valid_i ? trap_vec_i : redirect_pc_i;

`ifdef PC_ALIGN_CHECK_EN
  localparam int LOW_BITS = $clog2(INSTR_BYTES);

  logic [ADDR_WIDTH-1:0] align_mask;

  // Mask keeps only the bits at or above the instruction alignment.
  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align_mask
    assign align_mask[gi] = (gi >= LOW_BITS);
  end

  assign jump_load         = jump_target & align_mask;
  assign target_misaligned = |(jump_target & ~align_mask);
`else
  assign jump_load         = jump_target;
  assign target_misaligned = 1'b0;
`endif

  // Request valid comes straight off the state register, so it is glitch
  // free and independent of this cycle's inputs.
  assign fetch_valid_o = (state_reg == RUN);
  assign fire          = fetch_valid_o & fetch_ready_i & ~stall_i;

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    pc_next       = pc_reg;
    flush_next    = 1'b0;
    cnt_next      = cnt_reg;
    misalign_next = 1'b0;

    case (state_reg)
      BOOT: begin
        boot_cnt_next = boot_cnt_reg - 8'd1;
        if (boot_cnt_reg == 8'd1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase

    // Jumps are honoured in BOOT as well; they do not touch the boot timer.
    if (jump_valid) begin
      pc_next       = jump_load;
      flush_next    = 1'b1;
      misalign_next = target_misaligned;
      if (!(&cnt_reg)) begin
        cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
    end else if (fire) begin
      pc_next = pc_reg + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RESET_STATE;
      boot_cnt_reg <= BOOT_INIT;
      pc_reg       <= RESET_VECTOR;
      flush_reg    <= 1'b0;
      cnt_reg      <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
      pc_reg       <= pc_next;
      flush_reg    <= flush_next;
      cnt_reg      <= cnt_next;
      misalign_reg <= misalign_next;
    end
  end

  assign pc_o           = pc_reg;
  assign pc_plus_o      = pc_reg + PC_INC;
  assign flush_o        = flush_reg;
  assign redirect_cnt_o = cnt_reg;
  assign misalign_o     = misalign_reg;

endmodule
